// File: rtl/voxel_pkg.sv
// Shared types and defaults for the voxel feature streamer and the systolic classifier.
package voxel_pkg;

    localparam int DEF_NUM_CELLS       = 1024;
    localparam int DEF_PARALLEL_INPUTS = 4;
    localparam int DEF_VALUE_BITS      = 6;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_FLUSH  = 2'd2,
        S_WAIT   = 2'd3
    } streamer_state_t;

    function automatic int num_batches(input int cells, input int par);
        return (cells + par - 1) / par;
    endfunction

endpackage

// File: rtl/feature_lane_norm.sv
// One feature lane: right shift a raw bin count, saturate to VALUE_BITS, force 0 on padding lanes.
module feature_lane_norm #(
    parameter int COUNT_BITS = 8,
    parameter int VALUE_BITS = 6,
    parameter int NORM_SHIFT = 2
) (
    input  logic [COUNT_BITS-1:0] count_i,
    input  logic                  pad_i,
    output logic [VALUE_BITS-1:0] value_o
);

    // Work at the wider of the two widths so the saturation compare is always well defined.
    localparam int W = (COUNT_BITS > VALUE_BITS) ? COUNT_BITS : VALUE_BITS;
    localparam logic [W-1:0] MAX_V = W'((64'd1 << VALUE_BITS) - 64'd1);

    logic [W-1:0] shifted;

    always_comb begin
        shifted = W'(count_i) >> NORM_SHIFT;
        if (pad_i) begin
            value_o = '0;
        end else if (shifted > MAX_V) begin
            value_o = MAX_V[VALUE_BITS-1:0];
        end else begin
            value_o = shifted[VALUE_BITS-1:0];
        end
    end

endmodule

// File: rtl/voxel_feature_streamer.sv
// Streams a frozen voxel-bin frame to the classifier as normalised feature batches.
// Optional in-flight bank clearing is enabled by defining VOXEL_FEATURE_CLEAR_EN.
module voxel_feature_streamer
    import voxel_pkg::*;
#(
    parameter int NUM_CELLS       = DEF_NUM_CELLS,
    parameter int PARALLEL_INPUTS = DEF_PARALLEL_INPUTS,
    parameter int COUNT_BITS      = 8,
    parameter int VALUE_BITS      = DEF_VALUE_BITS,
    parameter int NORM_SHIFT      = 2,
    localparam int NUM_BATCHES    = num_batches(NUM_CELLS, PARALLEL_INPUTS),
    localparam int BADDR_BITS     = (NUM_BATCHES > 1) ? $clog2(NUM_BATCHES) : 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  frame_ready,
    output logic                                  frame_busy,
    output logic                                  frame_dropped,
    output logic                                  mem_rd_en,
    output logic [BADDR_BITS-1:0]                 mem_rd_addr,
    input  logic [PARALLEL_INPUTS*COUNT_BITS-1:0] mem_rd_data,
    output logic                                  mem_clr_en,
    output logic [BADDR_BITS-1:0]                 mem_clr_addr,
    output logic                                  sa_start,
    output logic [PARALLEL_INPUTS*VALUE_BITS-1:0] feature_in,
    output logic                                  feature_valid,
    input  logic                                  sa_result_valid,
    output logic                                  frame_done
);

    // state    | meaning
    // S_IDLE   | waiting for a frozen frame
    // S_STREAM | issuing one batch read per cycle
    // S_FLUSH  | reads done, draining the two-stage pipeline
    // S_WAIT   | all features sent, waiting for the classifier result

    localparam logic [BADDR_BITS-1:0] LAST_ADDR = BADDR_BITS'(NUM_BATCHES - 1);

    streamer_state_t state_q, state_d;
    logic                  rd_en_q, rd_en_d;
    logic [BADDR_BITS-1:0] rd_addr_q, rd_addr_d;
    logic                  start_q, start_d;
    logic                  dropped_q, dropped_d;
    logic                  done_q, done_d;

    logic                  s1_valid_q;
    logic [BADDR_BITS-1:0] s1_addr_q;
    logic                  fvalid_q;
    logic [PARALLEL_INPUTS*VALUE_BITS-1:0] feat_q;
    logic [PARALLEL_INPUTS*VALUE_BITS-1:0] lane_vals;

    always_comb begin
        state_d   = state_q;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        start_d   = 1'b0;
        dropped_d = frame_ready && (state_q != S_IDLE);
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (frame_ready) begin
                    start_d   = 1'b1;
                    rd_en_d   = 1'b1;
                    rd_addr_d = '0;
                    state_d   = S_STREAM;
                end
            end
            S_STREAM: begin
                if (rd_addr_q == LAST_ADDR) begin
                    state_d = S_FLUSH;
                end else begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = rd_addr_q + BADDR_BITS'(1);
                end
            end
            S_FLUSH: begin
                // Once stage 1 is empty, the final batch is on feature_in this cycle.
                if (!s1_valid_q) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (sa_result_valid) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            start_q   <= 1'b0;
            dropped_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            start_q   <= start_d;
            dropped_q <= dropped_d;
            done_q    <= done_d;
        end
    end

    for (genvar p = 0; p < PARALLEL_INPUTS; p++) begin : g_lane
        logic [31:0] cell_idx;
        logic        pad;

        assign cell_idx = 32'(s1_addr_q) * 32'(PARALLEL_INPUTS) + 32'(p);
        assign pad      = (cell_idx >= 32'(NUM_CELLS));

        feature_lane_norm #(
            .COUNT_BITS (COUNT_BITS),
            .VALUE_BITS (VALUE_BITS),
            .NORM_SHIFT (NORM_SHIFT)
        ) u_norm (
            .count_i (mem_rd_data[p*COUNT_BITS +: COUNT_BITS]),
            .pad_i   (pad),
            .value_o (lane_vals[p*VALUE_BITS +: VALUE_BITS])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_addr_q  <= '0;
            fvalid_q   <= 1'b0;
            feat_q     <= '0;
        end else begin
            s1_valid_q <= rd_en_q;
            s1_addr_q  <= rd_addr_q;
            fvalid_q   <= s1_valid_q;
            feat_q     <= s1_valid_q ? lane_vals : '0;
        end
    end

`ifdef VOXEL_FEATURE_CLEAR_EN
    // Clear each batch on the second port in the same cycle its data comes back.
    assign mem_clr_en   = s1_valid_q;
    assign mem_clr_addr = s1_valid_q ? s1_addr_q : '0;
`else
    assign mem_clr_en   = 1'b0;
    assign mem_clr_addr = '0;
`endif

    assign frame_busy    = (state_q != S_IDLE);
    assign frame_dropped = dropped_q;
    assign mem_rd_en     = rd_en_q;
    assign mem_rd_addr   = rd_addr_q;
    assign sa_start      = start_q;
    assign feature_in    = feat_q;
    assign feature_valid = fvalid_q;
    assign frame_done    = done_q;

endmodule

// File: tb/tb_voxel_feature_streamer.sv
// Directed bench for voxel_feature_streamer: 10 cells, 4 lanes, shift 2, 6-bit features.
module tb_voxel_feature_streamer;

    localparam int NC = 10;
    localparam int P  = 4;
    localparam int CB = 8;
    localparam int VB = 6;
    localparam int NS = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            frame_ready;
    logic            frame_busy;
    logic            frame_dropped;
    logic            mem_rd_en;
    logic [1:0]      mem_rd_addr;
    logic [P*CB-1:0] mem_rd_data;
    logic            mem_clr_en;
    logic [1:0]      mem_clr_addr;
    logic            sa_start;
    logic [P*VB-1:0] feature_in;
    logic            feature_valid;
    logic            sa_result_valid;
    logic            frame_done;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] mem [16];

    always #5 clk = ~clk;

    voxel_feature_streamer #(
        .NUM_CELLS       (NC),
        .PARALLEL_INPUTS (P),
        .COUNT_BITS      (CB),
        .VALUE_BITS      (VB),
        .NORM_SHIFT      (NS)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .frame_ready     (frame_ready),
        .frame_busy      (frame_busy),
        .frame_dropped   (frame_dropped),
        .mem_rd_en       (mem_rd_en),
        .mem_rd_addr     (mem_rd_addr),
        .mem_rd_data     (mem_rd_data),
        .mem_clr_en      (mem_clr_en),
        .mem_clr_addr    (mem_clr_addr),
        .sa_start        (sa_start),
        .feature_in      (feature_in),
        .feature_valid   (feature_valid),
        .sa_result_valid (sa_result_valid),
        .frame_done      (frame_done)
    );

    // Synchronous-read bin memory: data appears one cycle after the read strobe.
    always @(posedge clk) begin
        logic [P*CB-1:0] tmp;
        tmp = '0;
        if (mem_rd_en) begin
            for (int p = 0; p < P; p++) tmp[p*CB +: CB] = mem[int'(mem_rd_addr)*P + p];
            mem_rd_data <= tmp;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_lane(input int b, input int p);
        int idx;
        int v;
        idx = b*P + p;
        if (idx >= NC) return 32'd0;
        v = int'(mem[idx]) >> NS;
        return (v > 63) ? 32'd63 : 32'(v);
    endfunction

    task automatic check_all_zero(input string tag);
        check_val({tag, "_busy"},  32'(frame_busy), 0);
        check_val({tag, "_drop"},  32'(frame_dropped), 0);
        check_val({tag, "_rden"},  32'(mem_rd_en), 0);
        check_val({tag, "_rdadr"}, 32'(mem_rd_addr), 0);
        check_val({tag, "_clren"}, 32'(mem_clr_en), 0);
        check_val({tag, "_clradr"},32'(mem_clr_addr), 0);
        check_val({tag, "_start"}, 32'(sa_start), 0);
        check_val({tag, "_feat"},  32'(feature_in), 0);
        check_val({tag, "_fvld"},  32'(feature_valid), 0);
        check_val({tag, "_done"},  32'(frame_done), 0);
    endtask

    // Called at a negedge; frame_ready is sampled at the next posedge (edge 0).
    task automatic run_frame(input bit drop_stream, input bit drop_wait, input bit coincident,
                             input int abort_cyc, input bit check_sat);
        bit fv;
        frame_ready = 1'b1;
        for (int cyc = 1; cyc <= 7; cyc++) begin
            @(negedge clk);
            check_val("sa_start", 32'(sa_start), 32'(cyc == 1));
            check_val("busy", 32'(frame_busy), 1);
            check_val("done", 32'(frame_done), 0);
            check_val("dropped", 32'(frame_dropped), 32'(drop_stream && cyc == 3));
            check_val("rd_en", 32'(mem_rd_en), 32'(cyc >= 1 && cyc <= 3));
            if (cyc <= 3) check_val("rd_addr", 32'(mem_rd_addr), 32'(cyc - 1));
            fv = (cyc >= 3 && cyc <= 5);
            check_val("fvalid", 32'(feature_valid), 32'(fv));
            if (fv) begin
                for (int p = 0; p < P; p++)
                    check_val($sformatf("lane_b%0d_p%0d", cyc - 3, p),
                              32'(feature_in[p*VB +: VB]), exp_lane(cyc - 3, p));
            end
            if (check_sat && cyc == 3) begin
                check_val("sat255", 32'(feature_in[0 +: VB]), 63);
                check_val("cnt200", 32'(feature_in[VB +: VB]), 50);
                check_val("cnt3",   32'(feature_in[2*VB +: VB]), 0);
            end
`ifdef VOXEL_FEATURE_CLEAR_EN
            check_val("clr_en", 32'(mem_clr_en), 32'(cyc >= 2 && cyc <= 4));
            if (cyc >= 2 && cyc <= 4) check_val("clr_addr", 32'(mem_clr_addr), 32'(cyc - 2));
`else
            check_val("clr_en", 32'(mem_clr_en), 0);
            check_val("clr_addr", 32'(mem_clr_addr), 0);
`endif
            if (cyc == abort_cyc) begin
                rst_n = 1'b0;
                #1;
                check_all_zero("rst_async");
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                for (int k = 0; k < 6; k++) begin
                    @(negedge clk);
                    check_val("post_rst_fvalid", 32'(feature_valid), 0);
                    check_val("post_rst_rden", 32'(mem_rd_en), 0);
                    check_val("post_rst_busy", 32'(frame_busy), 0);
                end
                return;
            end
            frame_ready = (drop_stream && cyc == 2) || (drop_wait && cyc == 7);
        end
        @(negedge clk);
        check_val("wait_dropped", 32'(frame_dropped), 32'(drop_wait));
        check_val("wait_busy", 32'(frame_busy), 1);
        check_val("wait_start", 32'(sa_start), 0);
        check_val("wait_rden", 32'(mem_rd_en), 0);
        check_val("wait_fvalid", 32'(feature_valid), 0);
        check_val("wait_done", 32'(frame_done), 0);
        frame_ready     = coincident;
        sa_result_valid = 1'b1;
        @(negedge clk);
        check_val("res_done", 32'(frame_done), 1);
        check_val("res_busy", 32'(frame_busy), 0);
        check_val("res_dropped", 32'(frame_dropped), 32'(coincident));
        check_val("res_start", 32'(sa_start), 0);
        frame_ready     = 1'b0;
        sa_result_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n           = 1'b0;
        frame_ready     = 1'b0;
        sa_result_valid = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = (i < NC) ? 8'(4*i) : 8'hFF;
        #1;
        check_all_zero("reset");
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        sa_result_valid = 1'b1;
        @(negedge clk);
        check_val("idle_res_done", 32'(frame_done), 0);
        check_val("idle_res_busy", 32'(frame_busy), 0);
        sa_result_valid = 1'b0;
        @(negedge clk);

        // Ramp counts 0,4,8.. give features 0..9; pad lanes 10,11 hold 0xFF in memory.
        run_frame(1'b0, 1'b0, 1'b0, 0, 1'b0);

        // Back-to-back with saturating counts and drops in STREAM and WAIT.
        mem[0] = 8'd255;
        mem[1] = 8'd200;
        mem[2] = 8'd3;
        run_frame(1'b1, 1'b1, 1'b0, 0, 1'b1);

        // frame_ready coincident with the result is dropped, not started.
        run_frame(1'b0, 1'b0, 1'b1, 0, 1'b0);
        @(negedge clk);
        check_val("coinc_start", 32'(sa_start), 0);
        check_val("coinc_busy", 32'(frame_busy), 0);
        check_val("coinc_rden", 32'(mem_rd_en), 0);

        run_frame(1'b0, 1'b0, 1'b0, 4, 1'b0);
        run_frame(1'b0, 1'b0, 1'b0, 0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
